// File: rtl/sdram_bist_sequencer_if.sv
// Request-port bundle between the BIST sequencer (master) and the SDRAM
// controller (slave).
//   WrEN_Sig / RdEN_Sig : access requests, held until Done_Sig
//   BRC_Addr            : bank/row/column address
//   WrData              : write data
//   Done_Sig            : one-cycle completion pulse from the controller
//   RdData              : read data, valid with Done_Sig on reads
interface sdram_bist_sequencer_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 22
) ();
    logic          WrEN_Sig;
    logic          RdEN_Sig;
    logic [AW-1:0] BRC_Addr;
    logic [DW-1:0] WrData;
    logic          Done_Sig;
    logic [DW-1:0] RdData;

    modport master (
        output WrEN_Sig, RdEN_Sig, BRC_Addr, WrData,
        input  Done_Sig, RdData
    );

    modport slave (
        input  WrEN_Sig, RdEN_Sig, BRC_Addr, WrData,
        output Done_Sig, RdData
    );
endinterface

// File: rtl/sdram_bist_sequencer.sv
// Built-in self-test master for the SDRAM controller: writes a pattern over an
// address window, reads it back and compares, then reports pass/fail.
// Ports:
//   CLK, RST     : clock and synchronous active-high reset
//   Start_Sig    : one-cycle pulse starting a run (ignored while busy)
//   bus          : controller request port (master side)
//   Busy_Sig     : run in progress
//   Pass_Sig     : last run finished clean
//   Fail_Sig     : last run saw mismatches or a watchdog timeout
//   Tout_Sig     : the failure was a watchdog timeout
//   Err_Count    : saturating mismatch count
// Optional: define SDRAM_BIST_ERRLOG_EN to add Err_Addr/Err_Exp/Err_Got, which
// capture the first mismatch of a run.
module sdram_bist_sequencer #(
    parameter int unsigned   DW        = 16,
    parameter int unsigned   AW        = 22,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter int unsigned   NUM_WORDS = 256,
    parameter int unsigned   PATTERN   = 0,
    parameter int unsigned   TIMEOUT   = 1023
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Start_Sig,
    sdram_bist_sequencer_if.master bus,
    output logic                Busy_Sig,
    output logic                Pass_Sig,
    output logic                Fail_Sig,
    output logic                Tout_Sig,
    output logic [15:0]         Err_Count
`ifdef SDRAM_BIST_ERRLOG_EN
    ,
    output logic [AW-1:0]       Err_Addr,
    output logic [DW-1:0]       Err_Exp,
    output logic [DW-1:0]       Err_Got
`endif
);

    localparam int unsigned IdxW = $clog2(NUM_WORDS) + 1;
    localparam int unsigned WdW  = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {StIdle, StWrite, StWrGap, StRead, StRdGap, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [WdW-1:0]  wd_q, wd_d;
    logic            wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic            busy_d, pass_d, fail_d, tout_d;
    logic [15:0]     err_d;

    logic [AW-1:0]   addr;
    logic [DW-1:0]   addr_lo;
    logic [DW-1:0]   pat;
    logic            last, expire, mismatch;

    // Address wraps naturally modulo 2^AW.
    assign addr = BASE_ADDR + AW'(idx_q);

    if (AW >= DW) begin : g_addr_trunc
        assign addr_lo = addr[DW-1:0];
    end else begin : g_addr_ext
        assign addr_lo = {{(DW - AW){1'b0}}, addr};
    end

    always_comb begin
        if (PATTERN == 1) begin
            pat = ~addr_lo;
        end else if (PATTERN == 2) begin
            pat = DW'(1) << (32'(idx_q) % DW);
        end else begin
            pat = addr_lo;
        end
    end

    assign last     = (idx_q == IdxW'(NUM_WORDS - 1));
    assign mismatch = (bus.RdData != pat);
    // A Done_Sig arriving in the expiry cycle takes priority over the timeout.
    assign expire   = (TIMEOUT != 0) && (wd_q == WdW'(TIMEOUT - 1)) && !bus.Done_Sig;

    assign bus.WrEN_Sig = wr_en_q;
    assign bus.RdEN_Sig = rd_en_q;
    assign bus.BRC_Addr = (wr_en_q || rd_en_q) ? addr : '0;
    assign bus.WrData   = wr_en_q ? pat : '0;

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            wd_q      <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            Busy_Sig  <= 1'b0;
            Pass_Sig  <= 1'b0;
            Fail_Sig  <= 1'b0;
            Tout_Sig  <= 1'b0;
            Err_Count <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wd_q      <= wd_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            Busy_Sig  <= busy_d;
            Pass_Sig  <= pass_d;
            Fail_Sig  <= fail_d;
            Tout_Sig  <= tout_d;
            Err_Count <= err_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (Start_Sig) state_d = StWrite;
            StWrite: begin
                if (bus.Done_Sig)  state_d = StWrGap;
                else if (expire)   state_d = StDone;
            end
            StWrGap: state_d = last ? StRead : StWrite;
            StRead: begin
                if (bus.Done_Sig)  state_d = StRdGap;
                else if (expire)   state_d = StDone;
            end
            StRdGap: state_d = last ? StDone : StRead;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        idx_d  = idx_q;
        wd_d   = '0;
        err_d  = Err_Count;
        tout_d = Tout_Sig;
        pass_d = Pass_Sig;
        fail_d = Fail_Sig;
        unique case (state_q)
            StIdle: begin
                if (Start_Sig) begin
                    idx_d  = '0;
                    err_d  = '0;
                    tout_d = 1'b0;
                    pass_d = 1'b0;
                    fail_d = 1'b0;
                end
            end
            StWrite, StRead: begin
                // Watchdog restarts from zero on each new access.
                if (state_d == state_q) wd_d = wd_q + 1'b1;
                if (state_q == StRead && bus.Done_Sig && mismatch && Err_Count != 16'hFFFF) begin
                    err_d = Err_Count + 16'd1;
                end
                if (expire) tout_d = 1'b1;
            end
            StWrGap, StRdGap: idx_d = last ? '0 : idx_q + 1'b1;
            default: ;
        endcase
        if (state_d == StDone) begin
            pass_d = (err_d == '0) && !tout_d;
            fail_d = !pass_d;
        end
        wr_en_d = (state_d == StWrite);
        rd_en_d = (state_d == StRead);
        busy_d  = (state_d != StIdle) && (state_d != StDone);
    end

`ifdef SDRAM_BIST_ERRLOG_EN
    // Err_Count still at zero marks the first mismatch of the run.
    always_ff @(posedge CLK) begin
        if (RST || (state_q == StIdle && Start_Sig)) begin
            Err_Addr <= '0;
            Err_Exp  <= '0;
            Err_Got  <= '0;
        end else if (state_q == StRead && bus.Done_Sig && mismatch && Err_Count == '0) begin
            Err_Addr <= addr;
            Err_Exp  <= pat;
            Err_Got  <= bus.RdData;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_bist_sequencer.sv
module tb_sdram_bist_sequencer;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start   [2];
    logic          busy    [2];
    logic          pass    [2];
    logic          fail    [2];
    logic          tout    [2];
    logic [15:0]   err_cnt [2];
    logic          wren    [2];
    logic          rden    [2];
    logic          done    [2];
    logic [AW-1:0] addr    [2];
    logic [DW-1:0] wdata   [2];
    logic          done_r  [2];
    logic [DW-1:0] rd_r    [2];
    logic [2:0]    cnt     [2];
    logic [DW-1:0] mem     [2][8];
    int            mode    [2];
    logic          both_seen = 1'b0;
`ifdef SDRAM_BIST_ERRLOG_EN
    logic [AW-1:0] err_addr [2];
    logic [DW-1:0] err_exp  [2];
    logic [DW-1:0] err_got  [2];
`endif

    int n_checks = 0;
    int n_errors = 0;
    int wr_hi, wr_dn, rd_dn, last_done, fall_cyc;
    logic [AW-1:0] waddr [4];

    sdram_bist_sequencer_if #(.DW(DW), .AW(AW)) bus_a ();
    sdram_bist_sequencer_if #(.DW(DW), .AW(AW)) bus_b ();

    sdram_bist_sequencer #(
        .DW(DW), .AW(AW), .BASE_ADDR(22'h0), .NUM_WORDS(4), .PATTERN(0), .TIMEOUT(15)
    ) dut_a (
        .CLK(clk), .RST(rst), .Start_Sig(start[0]), .bus(bus_a),
        .Busy_Sig(busy[0]), .Pass_Sig(pass[0]), .Fail_Sig(fail[0]), .Tout_Sig(tout[0]),
        .Err_Count(err_cnt[0])
`ifdef SDRAM_BIST_ERRLOG_EN
        , .Err_Addr(err_addr[0]), .Err_Exp(err_exp[0]), .Err_Got(err_got[0])
`endif
    );

    sdram_bist_sequencer #(
        .DW(DW), .AW(AW), .BASE_ADDR(22'h3FFFFE), .NUM_WORDS(4), .PATTERN(2), .TIMEOUT(15)
    ) dut_b (
        .CLK(clk), .RST(rst), .Start_Sig(start[1]), .bus(bus_b),
        .Busy_Sig(busy[1]), .Pass_Sig(pass[1]), .Fail_Sig(fail[1]), .Tout_Sig(tout[1]),
        .Err_Count(err_cnt[1])
`ifdef SDRAM_BIST_ERRLOG_EN
        , .Err_Addr(err_addr[1]), .Err_Exp(err_exp[1]), .Err_Got(err_got[1])
`endif
    );

    assign wren[0]        = bus_a.WrEN_Sig;
    assign rden[0]        = bus_a.RdEN_Sig;
    assign addr[0]        = bus_a.BRC_Addr;
    assign wdata[0]       = bus_a.WrData;
    assign bus_a.Done_Sig = done_r[0];
    assign bus_a.RdData   = rd_r[0];
    assign done[0]        = done_r[0];
    assign wren[1]        = bus_b.WrEN_Sig;
    assign rden[1]        = bus_b.RdEN_Sig;
    assign addr[1]        = bus_b.BRC_Addr;
    assign wdata[1]       = bus_b.WrData;
    assign bus_b.Done_Sig = done_r[1];
    assign bus_b.RdData   = rd_r[1];
    assign done[1]        = done_r[1];

    // Controller model: Done 5 cycles after an enable rises. Mode 1 flips bit 0
    // on reads of address 2; mode 2 never answers.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            done_r[g] <= 1'b0;
            if (rst) begin
                cnt[g] <= '0;
            end else begin
                if (start[g] && !busy[g]) begin
                    for (int i = 0; i < 8; i++) mem[g][i] <= 16'hDEAD;
                end
                if ((wren[g] || rden[g]) && !done_r[g] && mode[g] != 2) begin
                    if (cnt[g] == 3'd4) begin
                        done_r[g] <= 1'b1;
                        cnt[g]    <= '0;
                        if (wren[g]) mem[g][addr[g][2:0]] <= wdata[g];
                        else rd_r[g] <= mem[g][addr[g][2:0]] ^
                                        ((mode[g] == 1 && addr[g] == 22'd2) ? 16'h1 : 16'h0);
                    end else begin
                        cnt[g] <= cnt[g] + 3'd1;
                    end
                end else begin
                    cnt[g] <= '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if ((wren[0] && rden[0]) || (wren[1] && rden[1])) both_seen <= 1'b1;
        assert (!(wren[0] && rden[0]) && !(wren[1] && rden[1]));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs(input int g);
        return {8'h0, wren[g], rden[g], busy[g], pass[g], fail[g], tout[g],
                |addr[g], |wdata[g], err_cnt[g]};
    endfunction

    // Starts a run on DUT g and follows it to completion; poke re-pulses Start mid-run.
    task automatic run(input int g, input bit poke);
        bit fin = 1'b0;
        wr_hi = 0; wr_dn = 0; rd_dn = 0; last_done = -1; fall_cyc = -1;
        @(negedge clk); start[g] = 1'b1;
        @(negedge clk); start[g] = 1'b0;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            if (poke && cyc == 10) start[g] = 1'b1;
            if (poke && cyc == 11) start[g] = 1'b0;
            if (wren[g]) wr_hi++;
            if (done[g] && wren[g]) begin
                if (wr_dn < 4) waddr[wr_dn] = addr[g];
                wr_dn++;
            end
            if (done[g] && rden[g]) begin
                rd_dn++;
                last_done = cyc;
            end
            if (!busy[g] && (pass[g] || fail[g])) begin
                fin = 1'b1;
                fall_cyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (!fin) check("run_bound", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        mode[0] = 0; mode[1] = 0;
        repeat (3) @(negedge clk);
        check("rst_outs_a", outs(0), 32'd0);
        check("rst_outs_b", outs(1), 32'd0);
        rst = 1'b0;

        // Ideal memory, pattern = address.
        run(0, 1'b0);
        check("t1_pass", 32'(pass[0]), 32'd1);
        check("t1_fail", 32'(fail[0]), 32'd0);
        check("t1_err", 32'(err_cnt[0]), 32'd0);
        check("t1_busy_fall", 32'(fall_cyc - last_done), 32'd2);
        check("t1_wr_hi", 32'(wr_hi), 32'd24);
        check("t1_rd_dn", 32'(rd_dn), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_waddr%0d", i), 32'(waddr[i]), 32'(i));
            check($sformatf("t1_mem%0d", i), 32'(mem[0][i]), 32'(i));
        end

        // Bit flip on address 2 read.
        mode[0] = 1;
        run(0, 1'b0);
        check("t2_pass", 32'(pass[0]), 32'd0);
        check("t2_fail", 32'(fail[0]), 32'd1);
        check("t2_err", 32'(err_cnt[0]), 32'd1);
        check("t2_tout", 32'(tout[0]), 32'd0);
`ifdef SDRAM_BIST_ERRLOG_EN
        check("t2_err_addr", 32'(err_addr[0]), 32'd2);
        check("t2_err_exp", 32'(err_exp[0]), 32'h2);
        check("t2_err_got", 32'(err_got[0]), 32'h3);
`endif

        // Controller never answers.
        mode[0] = 2;
        run(0, 1'b0);
        check("t3_wr_hi", 32'(wr_hi), 32'd15);
        check("t3_tout", 32'(tout[0]), 32'd1);
        check("t3_fail", 32'(fail[0]), 32'd1);
        check("t3_pass", 32'(pass[0]), 32'd0);
        check("t3_err", 32'(err_cnt[0]), 32'd0);
        check("t3_wr_dn", 32'(wr_dn), 32'd0);
        @(negedge clk);
        check("t3_idle_en", {30'd0, wren[0], rden[0]}, 32'd0);

        // Address wrap with walking-one data.
        run(1, 1'b0);
        check("t4_pass", 32'(pass[1]), 32'd1);
        check("t4_waddr0", 32'(waddr[0]), 32'h3FFFFE);
        check("t4_waddr1", 32'(waddr[1]), 32'h3FFFFF);
        check("t4_waddr2", 32'(waddr[2]), 32'h0);
        check("t4_waddr3", 32'(waddr[3]), 32'h1);
        check("t4_mem6", 32'(mem[1][6]), 32'h1);
        check("t4_mem7", 32'(mem[1][7]), 32'h2);
        check("t4_mem0", 32'(mem[1][0]), 32'h4);
        check("t4_mem1", 32'(mem[1][1]), 32'h8);

        // Reset during the read of word 1.
        mode[0] = 0;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (rden[0] && addr[0] == 22'd1) found = 1'b1;
            else @(negedge clk);
        end
        check("t5_reached_rd1", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_outs", outs(0), 32'd0);
        rst = 1'b0;
        run(0, 1'b0);
        check("t5_rerun_pass", 32'(pass[0]), 32'd1);
        check("t5_rerun_err", 32'(err_cnt[0]), 32'd0);

        // Start while busy is ignored.
        run(0, 1'b1);
        check("t6_pass", 32'(pass[0]), 32'd1);
        check("t6_wr_hi", 32'(wr_hi), 32'd24);
        check("t6_wr_dn", 32'(wr_dn), 32'd4);
        check("t6_rd_dn", 32'(rd_dn), 32'd4);
        check("excl_enables", 32'(both_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
